// File: rtl/branch_resolve.sv
// branch_resolve: queues branch-unit results, writes them back to the ROB and redirects/flushes fetch on a taken (mispredicted) branch.
// Optional statistics counters are built when BRANCH_RESOLVE_STATS_EN is defined.
module branch_resolve #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] br_tag,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic             in_ready,
  output logic             overflow,
  output logic             rob_wb_valid,
  output logic [TAG_W-1:0] rob_wb_tag,
  output logic [31:0]      rob_wb_val,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic [TAG_W-1:0] flush_tag,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] TAG_INVALID = '1;
  typedef enum logic [1:0] {IDLE, WB, REDIRECT, FLUSH} state_t;
  state_t            r_state;
  logic [TAG_W+32:0] r_mem [DEPTH];
  logic [AW:0]       r_wp, r_rp;
  logic [TAG_W-1:0]  r_tag;
  logic              r_taken;
  logic [31:0]       r_target;
  logic              w_empty, w_full, w_pop, w_in_valid, w_push;
  logic [TAG_W+32:0] w_head;
  assign w_empty    = r_wp == r_rp;
  assign w_full     = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign w_pop      = (r_state == IDLE) && !w_empty;
  assign in_ready   = !w_full || w_pop;
  assign w_in_valid = br_tag != TAG_INVALID;
  assign w_push     = w_in_valid && in_ready;
  assign w_head     = r_mem[r_rp[AW-1:0]];
  // a push into a full FIFO with a simultaneous pop reuses the slot being read out
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= {br_tag, br_taken, br_target};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_wp     <= '0;
      r_rp     <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_in_valid && !in_ready) overflow <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state        <= IDLE;
      r_tag          <= TAG_INVALID;
      r_taken        <= 1'b0;
      r_target       <= '0;
      rob_wb_valid   <= 1'b0;
      rob_wb_tag     <= TAG_INVALID;
      rob_wb_val     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      flush_tag      <= TAG_INVALID;
    end else begin
      case (r_state)
        IDLE: if (w_pop) begin
          r_state      <= WB;
          r_tag        <= w_head[TAG_W+32:33];
          r_taken      <= w_head[32];
          r_target     <= w_head[31:0];
          rob_wb_valid <= 1'b1;
          rob_wb_tag   <= w_head[TAG_W+32:33];
          rob_wb_val   <= {31'b0, w_head[32]};
        end
        WB: begin
          rob_wb_valid   <= 1'b0;
          rob_wb_tag     <= TAG_INVALID;
          rob_wb_val     <= '0;
          r_state        <= r_taken ? REDIRECT : IDLE;
          redirect_valid <= r_taken;
          redirect_pc    <= r_taken ? r_target : 32'd0;
        end
        REDIRECT: if (redirect_ready) begin
          r_state        <= FLUSH;
          redirect_valid <= 1'b0;
          redirect_pc    <= '0;
          flush          <= 1'b1;
          flush_tag      <= r_tag;
        end
        FLUSH: begin
          r_state   <= IDLE;
          flush     <= 1'b0;
          flush_tag <= TAG_INVALID;
        end
      endcase
    end
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] r_br_count, r_mispred_count;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else if (r_state == WB) begin
      if (r_br_count != '1) r_br_count <= r_br_count + 32'd1;
      if (r_taken && r_mispred_count != '1) r_mispred_count <= r_mispred_count + 32'd1;
    end
  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  assign br_count      = '0;
  assign mispred_count = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed vector table, corner sequences and randomized traffic against a queue-based reference model.
module tb_branch_resolve;
  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam logic [TAG_W-1:0] INV = '1;
  logic             clk = 1'b0, rst = 1'b0;
  logic [TAG_W-1:0] br_tag = INV;
  logic             br_taken = 1'b0;
  logic [31:0]      br_target = '0;
  logic             redirect_ready = 1'b0;
  logic             in_ready, overflow, rob_wb_valid, redirect_valid, flush;
  logic [TAG_W-1:0] rob_wb_tag, flush_tag;
  logic [31:0]      rob_wb_val, redirect_pc, br_count, mispred_count;

  always #5 clk = ~clk;

  branch_resolve #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_tag(br_tag), .br_taken(br_taken), .br_target(br_target),
    .in_ready(in_ready), .overflow(overflow), .rob_wb_valid(rob_wb_valid), .rob_wb_tag(rob_wb_tag),
    .rob_wb_val(rob_wb_val), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush(flush), .flush_tag(flush_tag),
    .br_count(br_count), .mispred_count(mispred_count)
  );

  typedef struct { logic [TAG_W-1:0] tag; logic taken; logic [31:0] target; } res_t;
  typedef struct {
    logic [TAG_W-1:0] tag; logic taken; logic [31:0] tgt; logic rr;
    logic wbv; logic [TAG_W-1:0] wbt; logic [31:0] wbval;
    logic rv; logic [31:0] pc; logic fl; logic [TAG_W-1:0] flt;
  } vec_t;

  res_t             q[$];
  res_t             cur;
  int               ph;
  logic             m_ovf;
  logic [31:0]      m_brc, m_mpc;
  int               checks = 0, errors = 0;
  logic [TAG_W-1:0] wb_seen[$];
  vec_t             tv[11];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ph = 0;
    m_ovf = 1'b0;
    m_brc = '0;
    m_mpc = '0;
    cur = '{INV, 1'b0, 32'd0};
  endtask

  // one rising edge of the spec'd behaviour: 0=idle 1=writeback 2=redirect 3=flush
  task automatic model_edge();
    bit pop, ir;
    pop = (ph == 0) && (q.size() > 0);
    ir = (q.size() < DEPTH) || pop;
    case (ph)
      0: if (pop) begin cur = q.pop_front(); ph = 1; end
      1: begin
        if (m_brc != 32'hFFFF_FFFF) m_brc++;
        if (cur.taken && m_mpc != 32'hFFFF_FFFF) m_mpc++;
        ph = cur.taken ? 2 : 0;
      end
      2: if (redirect_ready) ph = 3;
      default: ph = 0;
    endcase
    if (br_tag != INV) begin
      if (ir) q.push_back('{br_tag, br_taken, br_target});
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_check();
    chk("wb_valid", 64'(rob_wb_valid), 64'(ph == 1));
    chk("wb_tag", 64'(rob_wb_tag), 64'(ph == 1 ? cur.tag : INV));
    chk("wb_val", 64'(rob_wb_val), ph == 1 ? 64'(cur.taken) : 64'd0);
    chk("redirect_valid", 64'(redirect_valid), 64'(ph == 2));
    chk("redirect_pc", 64'(redirect_pc), ph == 2 ? 64'(cur.target) : 64'd0);
    chk("flush", 64'(flush), 64'(ph == 3));
    chk("flush_tag", 64'(flush_tag), 64'(ph == 3 ? cur.tag : INV));
    chk("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) || (ph == 0 && q.size() > 0)));
    chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("br_count", 64'(br_count), 64'(m_brc));
    chk("mispred_count", 64'(mispred_count), 64'(m_mpc));
`else
    chk("br_count", 64'(br_count), 64'd0);
    chk("mispred_count", 64'(mispred_count), 64'd0);
`endif
  endtask

  task automatic step(input logic [TAG_W-1:0] tag, input logic taken, input logic [31:0] tgt, input logic rr);
    br_tag = tag;
    br_taken = taken;
    br_target = tgt;
    redirect_ready = rr;
    model_edge();
    @(posedge clk);
    #1;
    if (rob_wb_valid) wb_seen.push_back(rob_wb_tag);
    model_check();
  endtask

  task automatic do_reset();
    br_tag = INV;
    br_taken = 1'b0;
    br_target = '0;
    redirect_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{5'd3, 1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b0, 32'd0,     1'b0, INV};
    tv[1]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b1, 5'd3, 32'd0, 1'b0, 32'd0,     1'b0, INV};
    tv[2]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b0, 32'd0,     1'b0, INV};
    tv[3]  = '{5'd7, 1'b1, 32'h100,   1'b0, 1'b0, INV,  32'd0, 1'b0, 32'd0,     1'b0, INV};
    tv[4]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b1, 5'd7, 32'd1, 1'b0, 32'd0,     1'b0, INV};
    tv[5]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b1, 32'h100,   1'b0, INV};
    tv[6]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b1, 32'h100,   1'b0, INV};
    tv[7]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b1, 32'h100,   1'b0, INV};
    tv[8]  = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b1, 32'h100,   1'b0, INV};
    tv[9]  = '{INV,  1'b0, 32'd0,     1'b1, 1'b0, INV,  32'd0, 1'b0, 32'd0,     1'b1, 5'd7};
    tv[10] = '{INV,  1'b0, 32'd0,     1'b0, 1'b0, INV,  32'd0, 1'b0, 32'd0,     1'b0, INV};

    // asynchronous reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_wb_valid", 64'(rob_wb_valid), 64'd0);
    chk("rst_wb_tag", 64'(rob_wb_tag), 64'(INV));
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_flush_tag", 64'(flush_tag), 64'(INV));
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step(tv[i].tag, tv[i].taken, tv[i].tgt, tv[i].rr);
      chk("tv_wb_valid", 64'(rob_wb_valid), 64'(tv[i].wbv));
      chk("tv_wb_tag", 64'(rob_wb_tag), 64'(tv[i].wbt));
      chk("tv_wb_val", 64'(rob_wb_val), 64'(tv[i].wbval));
      chk("tv_redirect_valid", 64'(redirect_valid), 64'(tv[i].rv));
      chk("tv_redirect_pc", 64'(redirect_pc), 64'(tv[i].pc));
      chk("tv_flush", 64'(flush), 64'(tv[i].fl));
      chk("tv_flush_tag", 64'(flush_tag), 64'(tv[i].flt));
    end

    // overflow: stall in REDIRECT so the FIFO fills, fifth push is dropped
    do_reset();
    step(5'd20, 1'b1, 32'h40, 1'b0);
    step(INV, 1'b0, 32'd0, 1'b0);
    step(INV, 1'b0, 32'd0, 1'b0);
    chk("ovf_in_redirect", 64'(redirect_valid), 64'd1);
    wb_seen.delete();
    for (int i = 1; i <= 5; i++) step(TAG_W'(i), 1'b0, 32'(i * 4), 1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_full", 64'(in_ready), 64'd0);
    for (int i = 0; i < 20; i++) step(INV, 1'b0, 32'd0, 1'b1);
    chk("ovf_wb_count", 64'(wb_seen.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("ovf_wb_order", 64'(wb_seen[i]), 64'(i + 1));
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // reset while a redirect is pending
    do_reset();
    step(5'd9, 1'b1, 32'h2000, 1'b0);
    step(INV, 1'b0, 32'd0, 1'b0);
    step(INV, 1'b0, 32'd0, 1'b0);
    chk("midrst_pre_redirect", 64'(redirect_valid), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_redirect", 64'(redirect_valid), 64'd0);
    chk("midrst_pc", 64'(redirect_pc), 64'd0);
    chk("midrst_flush", 64'(flush), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(INV, 1'b0, 32'd0, 1'b1);
      chk("midrst_no_flush", 64'(flush), 64'd0);
    end

    // statistics: six branches, two taken
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(TAG_W'(i + 10), (i == 1 || i == 4), 32'h800 + 32'(i), 1'b1);
      for (int j = 0; j < 6; j++) step(INV, 1'b0, 32'd0, 1'b1);
    end
`ifdef BRANCH_RESOLVE_STATS_EN
    chk("stats_br", 64'(br_count), 64'd6);
    chk("stats_mispred", 64'(mispred_count), 64'd2);
`else
    chk("stats_br", 64'(br_count), 64'd0);
    chk("stats_mispred", 64'(mispred_count), 64'd0);
`endif

    do_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1) != 0 ? TAG_W'($urandom_range(0, 30)) : INV,
           1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL have parameter TAG_W, default 5, ROB tag width; all-ones tag = TAG_INVALID.
REQ-002 SHALL have parameter DEPTH, default 4, result FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port br_tag  in  TAG_W  branch-unit result tag; != TAG_INVALID means a result is valid.
REQ-006 SHALL have port br_taken  in  1  branch-unit compare result.
REQ-007 SHALL have port br_target  in  32  branch-unit computed target (pc+offset).
REQ-008 SHALL have port in_ready  out  1  FIFO can accept a result this edge.
REQ-009 SHALL have port overflow  out  1  sticky: a valid result was dropped.
REQ-010 SHALL have port rob_wb_valid  out  1  one-cycle ROB writeback strobe.
REQ-011 SHALL have port rob_wb_tag  out  TAG_W  writeback tag.
REQ-012 SHALL have port rob_wb_val  out  32  {31'b0, taken}.
REQ-013 SHALL have port redirect_valid  out  1  fetch redirect request.
REQ-014 SHALL have port redirect_pc  out  32  redirect address.
REQ-015 SHALL have port redirect_ready  in  1  fetch accepts redirect.
REQ-016 SHALL have port flush  out  1  one-cycle squash pulse to ROB/reservation stations.
REQ-017 SHALL have port flush_tag  out  TAG_W  tag of mispredicted branch.
REQ-018 SHALL have ports br_count, mispred_count  out  32 each  statistics (see Configuration).

Function
REQ-019 SHALL push {br_tag, br_taken, br_target} into the FIFO at a rising edge when br_tag != TAG_INVALID and in_ready=1.
REQ-020 SHALL drive in_ready = !full || pop-this-edge; push while full without pop SHALL drop the result and set overflow until reset.
REQ-021 SHALL implement FSM states IDLE, WB, REDIRECT, FLUSH.
REQ-022 IDLE: if FIFO non-empty, pop head at that edge, latch it, go to WB; else stay.
REQ-023 WB (one cycle): rob_wb_valid=1 with latched tag/val; if taken go to REDIRECT, else go to IDLE.
REQ-024 REDIRECT: redirect_valid=1, redirect_pc=latched target held stable; on edge with redirect_ready=1 go to FLUSH.
REQ-025 FLUSH (one cycle): flush=1, flush_tag=latched tag; then IDLE.
REQ-026 Fetch predicts not-taken: taken == mispredict; not-taken branches SHALL never redirect or flush.
REQ-027 Latency: result pushed at edge N into empty FIFO in IDLE -> rob_wb_valid high during cycle after edge N+1.
REQ-028 Throughput: one not-taken result every 2 cycles; FIFO keeps accepting during REDIRECT/FLUSH.
REQ-029 FIFO SHALL NOT be cleared on flush; ROB discards writebacks of squashed tags.
REQ-030 Pointers SHALL wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-031 Outside their states, rob_wb_valid, redirect_valid, flush SHALL be 0; tag outputs TAG_INVALID.

Reset
REQ-032 rst SHALL immediately force IDLE, empty FIFO, overflow=0, all valid/flush outputs 0, tag outputs TAG_INVALID, data outputs 0, counters 0.
REQ-033 rst during REDIRECT SHALL abandon the redirect without a flush pulse.

Configuration
REQ-034 With BRANCH_RESOLVE_STATS_EN defined: br_count +1 per WB cycle, mispred_count +1 per WB with taken=1, both saturating at 32'hFFFF_FFFF.
REQ-035 Without BRANCH_RESOLVE_STATS_EN: ports present, tied to 0, no counter logic.

Verification
REQ-036 Push tag 3, taken=0 -> cycle after next edge: rob_wb_valid=1, tag 3, val 0; no redirect, no flush.
REQ-037 Push tag 7, taken=1, target 0x100; redirect_ready low 3 cycles -> redirect_valid held 4 cycles with pc 0x100, then flush=1 tag 7 for one cycle.
REQ-038 Push 5 results back-to-back with DEPTH=4, no gaps -> overflow=1, fifth result dropped, first four written back in order.
REQ-039 Assert rst mid-REDIRECT -> redirect_valid=0 immediately, no flush, FIFO empty, in_ready=1.
REQ-040 STATS_EN defined, 6 results with 2 taken -> br_count=6, mispred_count=2; undefined -> both 0.
